key_reader: RTL

Input-side conditioner for the board push-buttons: samples the raw `key` bus and synchronises each bit into the `clk` domain. It then debounces each bit with a per-key state machine and emits clean level and single-cycle press/release events. A small event counter drives the `led` bus, so the block is the sequential counterpart of the key-driving stimulus used across the combinational labs: it reads the key interface that those benches write.

---
 rtl/key_reader_pkg.sv | 20 ++
 rtl/key_debounce.sv | 118 +++++++++++
 rtl/key_reader.sv | 59 +++++
 3 files changed

// File: rtl/key_reader_pkg.sv
// Shared types and constants for the key_reader push-button conditioner.
// Contents: per-key debounce FSM state enum and the bit positions of the
//   fields packed onto the led bus.
package key_reader_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    WAIT_DOWN = 2'd1,
    DOWN      = 2'd2,
    WAIT_UP   = 2'd3
  } key_fsm_e;

  // led = {key_state[1:0], press_count[7:0]}
  localparam int LED_W         = 10;
  localparam int LED_CNT_LSB   = 0;
  localparam int LED_CNT_MSB   = 7;
  localparam int LED_STATE_LSB = 8;
  localparam int LED_STATE_MSB = 9;

endpackage : key_reader_pkg

// File: rtl/key_debounce.sv
// Single-key conditioner: polarity fix, 2-flop synchroniser, debounce FSM.
// Ports: clk_i/rst_i (async active-high), key_i raw button bit;
//   state_o debounced level (1 = pressed), press_o/release_o one-cycle pulses.
module key_debounce
  import key_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             raw;
  logic [1:0]       sync_q;
  logic             s;

  key_fsm_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             level_q, level_d;

  // Normalise to 1 = pressed before synchronising, so reset value 0 of the
  // synchroniser means "not pressed".
  assign raw = KEY_ACTIVE_LOW ? ~key_i : key_i;
  assign s   = sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      UP: begin
        if (s) begin
          state_d = WAIT_DOWN;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_DOWN: begin
        if (!s) begin
          // Glitch: restart from scratch.
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        if (!s) begin
          state_d = WAIT_UP;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_UP: begin
        if (s) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = UP;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
  end

  // Level is registered from the next state so it moves on the same edge
  // as the corresponding pulse.
  assign level_d = (state_d == DOWN) || (state_d == WAIT_UP);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= UP;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      level_q   <= level_d;
    end
  end

  assign state_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule : key_debounce

// File: rtl/key_reader.sv
// Push-button reader: per-key debounce plus an up/down event counter on led.
// Ports: clk, rst (async active-high), key raw buttons; key_state/key_press/
//   key_release per key; press_count (+key0, -key1); led = {state[1:0], count}.
module key_reader
  import key_reader_pkg::*;
#(
  parameter int KEY_WIDTH       = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_WIDTH-1:0] key,
  output logic [KEY_WIDTH-1:0] key_state,
  output logic [KEY_WIDTH-1:0] key_press,
  output logic [KEY_WIDTH-1:0] key_release,
  output logic [7:0]           press_count,
  output logic [LED_W-1:0]     led
);

  logic [7:0] count_q, count_d;

  for (genvar g = 0; g < KEY_WIDTH; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_debounce (
      .clk_i     (clk),
      .rst_i     (rst),
      .key_i     (key[g]),
      .state_o   (key_state[g]),
      .press_o   (key_press[g]),
      .release_o (key_release[g])
    );
  end

  // Key 0 counts up, key 1 counts down; simultaneous presses cancel.
  always_comb begin
    count_d = count_q;
    case ({key_press[1], key_press[0]})
      2'b01:   count_d = count_q + 8'd1;
      2'b10:   count_d = count_q - 8'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign press_count                       = count_q;
  assign led[LED_CNT_MSB:LED_CNT_LSB]      = count_q;
  assign led[LED_STATE_MSB:LED_STATE_LSB]  = key_state[1:0];

endmodule : key_reader
